// File: rtl/multi_tick_gen_pkg.sv
// multi_tick_gen_pkg
//   Shared definitions for the multi-channel tick generator.
//   - MODE_PULSE / MODE_SQUARE : per-channel output mode encoding
//   - ch_idx_w()               : width of a channel index (at least 1 bit)
package multi_tick_gen_pkg;

   localparam logic MODE_PULSE  = 1'b0;
   localparam logic MODE_SQUARE = 1'b1;

   // Channel-select width; a single channel still gets a 1-bit select.
   function automatic int ch_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/multi_tick_gen_chan.sv
// tick_chan
//   One divide-by-D tick channel with a shadowed divide/mode pair.
//   Ports:
//     clk, reset   : clock, async active-high reset
//     en           : channel enable (chooses shadow vs. direct config load)
//     adv          : advance event for this cycle (already gated by en)
//     sync_clr     : synchronous clear; applies a pending shadow pair
//     cfg_we       : write strobe already decoded for this channel
//     cfg_div      : new divide value (0 is treated as 1)
//     cfg_mode     : new mode (MODE_PULSE / MODE_SQUARE)
//     wrap         : combinational wrap strobe, feeds the next cascade stage
//     tick, sq     : registered outputs
module tick_chan
   import multi_tick_gen_pkg::*;
#(
   parameter int DIV_W       = 17,
   parameter int DEFAULT_DIV = 100_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             adv,
   input  logic             sync_clr,
   input  logic             cfg_we,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_mode,
   output logic             wrap,
   output logic             tick,
   output logic             sq
);

   localparam logic [DIV_W-1:0] DEF_DIV = (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] sh_div_q, sh_div_d;
   logic             mode_q, mode_d;
   logic             sh_mode_q, sh_mode_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;
   logic [DIV_W-1:0] cfg_div_eff;

   assign cfg_div_eff = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
   assign wrap        = adv && (cnt_q == div_q - DIV_W'(1));

   always_comb begin
      cnt_d     = cnt_q;
      div_d     = div_q;
      mode_d    = mode_q;
      sh_div_d  = sh_div_q;
      sh_mode_d = sh_mode_q;
      pend_d    = pend_q;
      tick_d    = 1'b0;
      sq_d      = sq_q;

      if (sync_clr) begin
         if (pend_q) begin
            div_d  = sh_div_q;
            mode_d = sh_mode_q;
         end
         pend_d = 1'b0;
         cnt_d  = '0;
         sq_d   = 1'b0;
      end else if (cfg_we && !en) begin
         // Idle channel: no period in flight, so load the active pair now.
         div_d  = cfg_div_eff;
         mode_d = cfg_mode;
         pend_d = 1'b0;
         cnt_d  = '0;
         sq_d   = 1'b0;
      end else begin
         if (cfg_we) begin
            sh_div_d  = cfg_div_eff;
            sh_mode_d = cfg_mode;
            pend_d    = 1'b1;
         end
         if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            // The mode that governed the finished period decides this edge.
            sq_d   = (mode_q == MODE_SQUARE) ? ~sq_q : 1'b1;
            // A write landing on the wrap cycle takes effect right here.
            if (cfg_we) begin
               div_d  = cfg_div_eff;
               mode_d = cfg_mode;
               pend_d = 1'b0;
            end else if (pend_q) begin
               div_d  = sh_div_q;
               mode_d = sh_mode_q;
               pend_d = 1'b0;
            end
         end else begin
            if (adv) cnt_d = cnt_q + DIV_W'(1);
            // Pulse mode mirrors tick, which is low whenever there is no wrap.
            if (mode_q == MODE_PULSE) sq_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         div_q     <= DEF_DIV;
         mode_q    <= MODE_PULSE;
         sh_div_q  <= DEF_DIV;
         sh_mode_q <= MODE_PULSE;
         pend_q    <= 1'b0;
         tick_q    <= 1'b0;
         sq_q      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         mode_q    <= mode_d;
         sh_div_q  <= sh_div_d;
         sh_mode_q <= sh_mode_d;
         pend_q    <= pend_d;
         tick_q    <= tick_d;
         sq_q      <= sq_d;
      end
   end

   assign tick = tick_q;
   assign sq   = sq_q;

endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen
//   NCH independent programmable tick generators (pulse or square output).
//   Ports:
//     clk, reset        : clock, async active-high reset
//     ch_en[NCH]        : per-channel count enable
//     sync_clr          : clear all counters/outputs, apply pending configs
//     cfg_we/cfg_ch     : one-cycle config write to channel cfg_ch
//     cfg_div/cfg_mode  : divide value and mode for the write
//     tick[NCH], sq[NCH]: registered tick and square outputs
//   Build option: define MULTI_TICK_GEN_CASCADE_EN to chain channels so that
//   channel k advances only on the wrap strobe of channel k-1.
module multi_tick_gen
   import multi_tick_gen_pkg::*;
#(
   parameter int NCH         = 4,
   parameter int DIV_W       = 17,
   parameter int DEFAULT_DIV = 100_000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NCH-1:0]              ch_en,
   input  logic                        sync_clr,
   input  logic                        cfg_we,
   input  logic [ch_idx_w(NCH)-1:0]    cfg_ch,
   input  logic [DIV_W-1:0]            cfg_div,
   input  logic                        cfg_mode,
   output logic [NCH-1:0]              tick,
   output logic [NCH-1:0]              sq
);

   localparam int CH_W = ch_idx_w(NCH);

   logic [NCH-1:0] adv;
   logic [NCH-1:0] ch_we;
`ifdef MULTI_TICK_GEN_CASCADE_EN
   logic [NCH-1:0] wrap;
`else
   logic [NCH-1:0] unused_wrap;
`endif

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      // Out-of-range cfg_ch values match no channel and are dropped.
      assign ch_we[k] = cfg_we && (cfg_ch == CH_W'(k));

`ifdef MULTI_TICK_GEN_CASCADE_EN
      if (k == 0) begin : g_head
         assign adv[k] = ch_en[k];
      end else begin : g_link
         assign adv[k] = ch_en[k] & wrap[k-1];
      end
`else
      assign adv[k] = ch_en[k];
`endif

      tick_chan #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .en       (ch_en[k]),
         .adv      (adv[k]),
         .sync_clr (sync_clr),
         .cfg_we   (ch_we[k]),
         .cfg_div  (cfg_div),
         .cfg_mode (cfg_mode),
`ifdef MULTI_TICK_GEN_CASCADE_EN
         .wrap     (wrap[k]),
`else
         .wrap     (unused_wrap[k]),
`endif
         .tick     (tick[k]),
         .sq       (sq[k])
      );
   end

endmodule

// File: doc/multi_tick_gen.md
MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent tick channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 17: width of divide value.
REQ-003 SHALL have parameter DEFAULT_DIV, default 100_000: divide value loaded into every channel at reset.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ch_en  input  NCH  per-channel count enable.
REQ-007 SHALL have port sync_clr  input  1  synchronous clear of all channel counters and outputs.
REQ-008 SHALL have port cfg_we  input  1  one-cycle configuration write strobe.
REQ-009 SHALL have port cfg_ch  input  clog2(NCH) (min 1)  target channel of the write.
REQ-010 SHALL have port cfg_div  input  DIV_W  new divide value.
REQ-011 SHALL have port cfg_mode  input  1  new mode: 0 = pulse, 1 = square.
REQ-012 SHALL have port tick  output  NCH  registered one-cycle tick per channel.
REQ-013 SHALL have port sq  output  NCH  registered square-wave output per channel.

Function
REQ-014 Each channel SHALL hold a counter, an active divide/mode pair, a shadow divide/mode pair, and a pending flag.
REQ-015 A cfg_div of 0 SHALL be treated as 1 when captured.
REQ-016 With ch_en[k]=1, counter k SHALL advance by 1 per advance event. On the advance where counter == active_div-1 (wrap), it SHALL instead return to 0.
REQ-017 tick[k] SHALL be 1 for exactly the cycle after a wrap and 0 otherwise. With divide D, the tick period SHALL be D cycles; D=1 gives tick held at 1.
REQ-018 In square mode, sq[k] SHALL toggle in the cycle after each wrap, giving period 2*D. In pulse mode, sq[k] SHALL follow tick[k].
REQ-019 With ch_en[k]=0, counter k and sq[k] SHALL hold their values and tick[k] SHALL be 0. Counting SHALL resume from the held count.
REQ-020 A cfg_we targeting an enabled channel SHALL store the values in the shadow pair and set pending. The shadow pair SHALL become active at that channel's next wrap, and the old divide SHALL govern the current period.
REQ-021 A cfg_we targeting a disabled channel SHALL load the active pair directly, clear counter and sq to 0, and clear pending.
REQ-022 If cfg_we and a wrap occur on the same channel in the same cycle, the written values SHALL become active at that wrap.
REQ-023 A second write before the pending write is applied SHALL overwrite the shadow pair; only the last write is applied.
REQ-024 A cfg_we with cfg_ch >= NCH SHALL be ignored.
REQ-025 sync_clr SHALL zero every counter, tick and sq, and SHALL apply any pending shadow pair immediately.
REQ-026 Priority SHALL be: reset > sync_clr > cfg write > count.

Reset
REQ-027 On reset, each channel SHALL take these values: counter=0, active_div=DEFAULT_DIV, mode=pulse, shadow=DEFAULT_DIV/pulse, pending=0, tick=0, sq=0.
REQ-028 Reset asserted mid-period SHALL abandon the period and any pending write. No tick SHALL be emitted on release.

Configuration
REQ-029 Macro MULTI_TICK_GEN_CASCADE_EN: when defined, channel k>0 SHALL advance only in cycles in which channel k-1 has its internal wrap strobe asserted (same cycle, no added latency per stage), and channel 0 SHALL advance every clk.
REQ-030 When MULTI_TICK_GEN_CASCADE_EN is undefined, every enabled channel SHALL advance every clk, and no inter-channel logic SHALL exist.
REQ-031 In cascade mode, a disabled channel k-1 SHALL stall channel k, because channel k receives no advance events.

Structure
REQ-032 Package multi_tick_gen_pkg SHALL hold the mode encoding constants (MODE_PULSE=0, MODE_SQUARE=1) and the channel-index width function.
REQ-033 Per-channel logic SHALL be one sub-module, tick_chan, generated NCH times. tick_chan SHALL have an advance input and a wrap-strobe output for cascading.

Verification
REQ-034 Reset release, ch_en[0]=1, default DIV=100_000 -> first tick[0] 100_000 cycles after the first enabled edge, then every 100_000 cycles.
REQ-035 Channel 1 disabled, write div=5 mode=square, then enable -> sq[1] toggles every 5 cycles (period 10), and tick[1] pulses every 5 cycles.
REQ-036 Channel 2 running with div=8, write div=3 at count 2 -> next tick 6 cycles later (old period completes), then ticks every 3 cycles.
REQ-037 Write div=0 to channel 3, enable -> tick[3] held at 1 every cycle; then sync_clr -> all tick/sq 0 and counters restart at 0.
REQ-038 Cascade build, ch0 div=4, ch1 div=3, both enabled -> tick[1] every 12 cycles; drop ch_en[0] -> tick[1] stops.
REQ-039 Reset asserted with a write pending on channel 0 -> after release, channel 0 uses DEFAULT_DIV, and cfg_ch=NCH writes change nothing.
